// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-source UART TX arbiter: FSM encoding,
// source indices and default timing parameters.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    localparam int SRC0 = 0;
    localparam int SRC1 = 1;

    localparam int IDLE_TIMEOUT_DFLT = 64;
    localparam int CNT_W_DFLT        = 16;

    // Idle counter must be able to hold IDLE_TIMEOUT itself.
    function automatic int idle_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int IDLE_CNT_W = idle_cnt_w(IDLE_TIMEOUT_DFLT);

endpackage

// File: rtl/stream_reg_slice.sv
// One-stage valid/ready register slice. Accepts a new beat in the same cycle
// the held beat drains, so it sustains one beat per cycle.
module stream_reg_slice #(
    parameter int W = 8
) (
    input  logic         hclk,
    input  logic         hresetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte stream between
// the USB CDC OUT stream (src0) and the CPU console stream (src1).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DFLT,
    parameter int CNT_W        = CNT_W_DFLT
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic [1:0]       src_en,
    input  logic             s0_tvalid,
    output logic             s0_tready,
    input  logic [7:0]       s0_tdata,
    input  logic             s0_tlast,
    input  logic             s1_tvalid,
    output logic             s1_tready,
    input  logic [7:0]       s1_tdata,
    input  logic             s1_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [7:0]       m_tdata,
    output logic [1:0]       grant,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int ICNT_W = idle_cnt_w(IDLE_TIMEOUT);
    localparam logic [ICNT_W-1:0] IDLE_LAST = ICNT_W'(IDLE_TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic              rr_q, rr_d;
    logic [ICNT_W-1:0] idle_q, idle_d;

    logic       slot_free;
    logic [1:0] req;
    logic [1:0] acc;
    logic       backpressure;
    logic       own1, own_en, own_valid, own_acc, own_last;

    assign req          = {s1_tvalid, s0_tvalid} & src_en;
    assign acc          = {s1_tvalid & s1_tready, s0_tvalid & s0_tready};
    assign backpressure = m_tvalid && !m_tready;

    assign own1      = (state_q == GRANT1);
    assign own_en    = own1 ? src_en[SRC1] : src_en[SRC0];
    assign own_valid = own1 ? s1_tvalid    : s0_tvalid;
    assign own_acc   = own1 ? acc[SRC1]    : acc[SRC0];
    assign own_last  = own1 ? s1_tlast     : s0_tlast;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idle_q  <= idle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (req == 2'b11) begin
                    state_d = rr_q ? GRANT1 : GRANT0;
                end else if (req[SRC0]) begin
                    state_d = GRANT0;
                end else if (req[SRC1]) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // Every release hands priority to the other source.
                if (!own_en) begin
                    state_d = IDLE;
                    rr_d    = !own1;
                    idle_d  = '0;
                end else if (own_acc) begin
                    idle_d = '0;
                    if (own_last) begin
                        state_d = IDLE;
                        rr_d    = !own1;
                    end
                end else if (!own_valid && !backpressure) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = IDLE;
                        rr_d    = !own1;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        grant     = 2'b00;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state_q)
            GRANT0: begin
                grant     = 2'b01;
                s0_tready = src_en[SRC0] && slot_free;
            end
            GRANT1: begin
                grant     = 2'b10;
                s1_tready = src_en[SRC1] && slot_free;
            end
            default: begin
            end
        endcase
    end

    stream_reg_slice #(
        .W(8)
    ) u_out_slice (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .in_valid (|acc),
        .in_ready (slot_free),
        .in_data  (acc[SRC1] ? s1_tdata : s0_tdata),
        .out_valid(m_tvalid),
        .out_ready(m_tready),
        .out_data (m_tdata)
    );

    logic [CNT_W-1:0] cnt_w [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_cnt) begin
                cnt_d = '0;
            end else if (acc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge hclk or negedge hresetn) begin
            if (!hresetn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_w[gi] = cnt_q;
    end

    assign cnt0 = cnt_w[SRC0];
    assign cnt1 = cnt_w[SRC1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: reset, table-driven packet test,
// directed corner sequences and a randomized run against a scoreboard model.
module tb_uart_tx_arbiter;

    localparam int TO   = 64;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic          hclk;
    logic          hresetn;
    logic [1:0]    src_en;
    logic          sv [2];
    logic [7:0]    sd [2];
    logic          sl [2];
    logic          s0_tready, s1_tready;
    logic          m_tvalid, m_tready;
    logic [7:0]    m_tdata;
    logic [1:0]    grant;
    logic          clr_cnt;
    logic [CW-1:0] cnt0, cnt1;

    uart_tx_arbiter #(
        .IDLE_TIMEOUT(TO),
        .CNT_W       (CW)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .src_en   (src_en),
        .s0_tvalid(sv[0]),
        .s0_tready(s0_tready),
        .s0_tdata (sd[0]),
        .s0_tlast (sl[0]),
        .s1_tvalid(sv[1]),
        .s1_tready(s1_tready),
        .s1_tdata (sd[1]),
        .s1_tlast (sl[1]),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .grant    (grant),
        .clr_cnt  (clr_cnt),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: bytes in flight, per-source counts, owner and priority.
    logic [7:0] q [$];
    int         mc [2];
    logic [1:0] exp_grant;
    bit         rr;
    int         idle_run;
    bit         acc [2];

    // Source generators.
    bit manual;
    bit gen_on [2];
    int fix_len [2];
    int pv [2];
    int seq [2];
    int bip [2];
    int cur_len [2];

    function automatic logic tr(input int s);
        return (s == 1) ? s1_tready : s0_tready;
    endfunction

    task automatic new_len(input int s);
        cur_len[s] = (fix_len[s] > 0) ? fix_len[s] : int'($urandom_range(1, 4));
    endtask

    task automatic drive_sources();
        for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
                if (sl[s]) begin
                    bip[s] = 0;
                    new_len(s);
                end else begin
                    bip[s]++;
                end
                seq[s]++;
                sv[s] = 1'b0;
            end
            if (!manual && !sv[s] && gen_on[s] && (int'($urandom_range(0, 99)) < pv[s])) begin
                sv[s] = 1'b1;
                sd[s] = {s[0], seq[s][6:0]};
                sl[s] = (bip[s] == cur_len[s] - 1);
            end
        end
    endtask

    task automatic monitor();
        logic [1:0] g;
        logic [1:0] rq;
        int         o;
        bit         rel;
        g = grant;
        if (!hresetn) begin
            q.delete();
            mc[0] = 0; mc[1] = 0;
            exp_grant = 2'b00; rr = 1'b0; idle_run = 0;
            acc[0] = 1'b0; acc[1] = 1'b0;
            return;
        end
        check("grant", {30'd0, g}, {30'd0, exp_grant});
        for (int s = 0; s < 2; s++) begin
            check($sformatf("s%0d_tready", s), {31'd0, tr(s)},
                  {31'd0, g[s] & src_en[s] & (!m_tvalid | m_tready)});
            acc[s] = sv[s] & tr(s);
        end
        check("m_tvalid", {31'd0, m_tvalid}, {31'd0, q.size() != 0});
        if (q.size() != 0) check("m_tdata", {24'd0, m_tdata}, {24'd0, q[0]});
        if (m_tvalid && m_tready && q.size() != 0) void'(q.pop_front());
        for (int s = 0; s < 2; s++) if (acc[s]) q.push_back(sd[s]);
        check("cnt0", {22'd0, cnt0}, mc[0]);
        check("cnt1", {22'd0, cnt1}, mc[1]);
        for (int s = 0; s < 2; s++) begin
            if (clr_cnt) mc[s] = 0;
            else if (acc[s] && mc[s] < CMAX) mc[s]++;
        end
        // Next owner follows the arbitration rules.
        if (g == 2'b00) begin
            rq = {sv[1] & src_en[1], sv[0] & src_en[0]};
            idle_run = 0;
            if (rq == 2'b11) exp_grant = rr ? 2'b10 : 2'b01;
            else exp_grant = rq;
        end else begin
            o   = g[1] ? 1 : 0;
            rel = !src_en[o] || (acc[o] && sl[o]);
            if (acc[o]) idle_run = 0;
            else if (!sv[o] && !(m_tvalid && !m_tready)) begin
                idle_run++;
                if (idle_run >= TO) rel = 1'b1;
            end
            if (rel) begin
                exp_grant = 2'b00;
                rr        = (o == 0);
                idle_run  = 0;
            end else begin
                exp_grant = g;
            end
        end
    endtask

    task automatic fin();
        monitor();
        @(posedge hclk);
        #1;
    endtask

    task automatic half();
        drive_sources();
        @(negedge hclk);
    endtask

    task automatic step();
        half();
        fin();
    endtask

    task automatic do_reset();
        manual = 1'b1;
        gen_on[0] = 1'b0; gen_on[1] = 1'b0;
        sv[0] = 1'b0; sv[1] = 1'b0;
        sd[0] = 8'h00; sd[1] = 8'h00;
        sl[0] = 1'b0; sl[1] = 1'b0;
        bip[0] = 0; bip[1] = 0;
        clr_cnt = 1'b0; m_tready = 1'b1; src_en = 2'b11;
        acc[0] = 1'b0; acc[1] = 1'b0;
        hresetn = 1'b0;
        repeat (3) step();
        hresetn = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic [1:0] g;
        logic       rdy;
        logic       mv;
        logic [7:0] md;
        int         c0;
    } vec_t;

    vec_t       tbl [7];
    logic [1:0] gq [$];
    logic       oq [$];
    logic [1:0] prev_g;
    logic [7:0] exp_held;

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        hresetn = 1'b0;
        seq[0] = 0; seq[1] = 0;
        fix_len[0] = 0; fix_len[1] = 0;
        pv[0] = 100; pv[1] = 100;
        new_len(0); new_len(1);
        do_reset();

        // Reset state with both sources requesting.
        hresetn = 1'b0;
        sv[0] = 1'b1; sv[1] = 1'b1;
        @(negedge hclk);
        check("rst_grant", {30'd0, grant}, 0);
        check("rst_m_tvalid", {31'd0, m_tvalid}, 0);
        check("rst_m_tdata", {24'd0, m_tdata}, 0);
        check("rst_cnt0", {22'd0, cnt0}, 0);
        check("rst_cnt1", {22'd0, cnt1}, 0);
        check("rst_s0_tready", {31'd0, s0_tready}, 0);
        check("rst_s1_tready", {31'd0, s1_tready}, 0);
        fin();
        do_reset();

        // Single 4-byte src0 packet, table driven.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 0};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 0};
        tbl[2] = '{1'b1, 8'h12, 1'b0, 2'b01, 1'b1, 1'b1, 8'h11, 1};
        tbl[3] = '{1'b1, 8'h13, 1'b0, 2'b01, 1'b1, 1'b1, 8'h12, 2};
        tbl[4] = '{1'b1, 8'h14, 1'b1, 2'b01, 1'b1, 1'b1, 8'h13, 3};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 8'h14, 4};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 4};
        for (int i = 0; i < 7; i++) begin
            sv[0] = tbl[i].v; sd[0] = tbl[i].d; sl[0] = tbl[i].l;
            @(negedge hclk);
            check($sformatf("tbl%0d_grant", i), {30'd0, grant}, {30'd0, tbl[i].g});
            check($sformatf("tbl%0d_s0_tready", i), {31'd0, s0_tready}, {31'd0, tbl[i].rdy});
            check($sformatf("tbl%0d_m_tvalid", i), {31'd0, m_tvalid}, {31'd0, tbl[i].mv});
            if (tbl[i].mv) check($sformatf("tbl%0d_m_tdata", i), {24'd0, m_tdata}, {24'd0, tbl[i].md});
            check($sformatf("tbl%0d_cnt0", i), {22'd0, cnt0}, tbl[i].c0);
            fin();
        end

        // Both sources with back-to-back 2-byte packets.
        do_reset();
        manual = 1'b0;
        gen_on[0] = 1'b1; gen_on[1] = 1'b1;
        fix_len[0] = 2; fix_len[1] = 2;
        pv[0] = 100; pv[1] = 100;
        new_len(0); new_len(1);
        prev_g = 2'b00;
        for (int i = 0; i < 24; i++) begin
            half();
            if (prev_g == 2'b00 && grant != 2'b00) gq.push_back(grant);
            if (m_tvalid && m_tready) oq.push_back(m_tdata[7]);
            prev_g = grant;
            fin();
        end
        check("rr_grant_count", {31'd0, gq.size() >= 4}, 1);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check($sformatf("rr_grant%0d", i), {30'd0, gq[i]}, (i % 2 == 0) ? 1 : 2);
        for (int i = 0; i + 1 < oq.size() && i < 12; i += 2)
            check($sformatf("pkt_intact%0d", i / 2), {31'd0, oq[i + 1]}, {31'd0, oq[i]});

        // src1 sends one byte then goes silent until the idle timeout.
        do_reset();
        sv[1] = 1'b1; sd[1] = 8'hA0; sl[1] = 1'b0;
        for (int k = 0; k < 10 && !acc[1]; k++) step();
        check("to_first_accept", {31'd0, acc[1]}, 1);
        sv[0] = 1'b1; sd[0] = 8'h55; sl[0] = 1'b1;
        for (int i = 1; i <= TO; i++) begin
            half();
            if (i == TO) check("to_hold_64", {30'd0, grant}, 2'b10);
            fin();
        end
        half();
        check("to_release", {30'd0, grant}, 2'b00);
        fin();
        half();
        check("to_src0_next", {30'd0, grant}, 2'b01);
        fin();
        repeat (3) step();

        // Backpressure for 20 cycles mid-packet.
        do_reset();
        manual = 1'b0;
        gen_on[0] = 1'b1; fix_len[0] = 6; pv[0] = 100; bip[0] = 0;
        new_len(0);
        repeat (4) step();
        m_tready = 1'b0;
        half();
        exp_held = (q.size() != 0) ? q[0] : 8'hxx;
        fin();
        repeat (18) step();
        half();
        check("bp_m_tvalid", {31'd0, m_tvalid}, 1);
        check("bp_data_stable", {24'd0, m_tdata}, {24'd0, exp_held});
        check("bp_s0_tready", {31'd0, s0_tready}, 0);
        check("bp_grant", {30'd0, grant}, 2'b01);
        fin();
        m_tready = 1'b1;
        repeat (12) step();
        gen_on[0] = 1'b0;
        repeat (4) step();

        // Long backpressure with the owner silent must not time out.
        do_reset();
        sv[0] = 1'b1; sd[0] = 8'h77; sl[0] = 1'b0;
        for (int k = 0; k < 10 && !acc[0]; k++) step();
        m_tready = 1'b0;
        repeat (70) step();
        half();
        check("bp_idle_grant", {30'd0, grant}, 2'b01);
        check("bp_idle_data", {24'd0, m_tdata}, 8'h77);
        fin();
        m_tready = 1'b1;
        repeat (2) step();

        // Disable src0 mid-packet while src1 waits.
        do_reset();
        manual = 1'b0;
        gen_on[0] = 1'b1; fix_len[0] = 8; pv[0] = 100; bip[0] = 0;
        new_len(0);
        sv[1] = 1'b1; sd[1] = 8'hB1; sl[1] = 1'b1;
        repeat (4) step();
        drive_sources();
        src_en = 2'b10;
        @(negedge hclk);
        check("en_drop_s0_tready", {31'd0, s0_tready}, 0);
        check("en_drop_queued", {31'd0, m_tvalid}, 1);
        fin();
        step();
        half();
        check("en_drop_src1_grant", {30'd0, grant}, 2'b10);
        fin();
        repeat (3) step();
        src_en = 2'b11;
        gen_on[0] = 1'b0;
        repeat (4) step();

        // Counter saturation, clear-wins, then reset mid-packet.
        do_reset();
        manual = 1'b0;
        gen_on[0] = 1'b1; fix_len[0] = 1 << 20; pv[0] = 100; bip[0] = 0;
        new_len(0);
        repeat (CMAX + 5) step();
        half();
        check("cnt_saturate", {22'd0, cnt0}, CMAX);
        fin();
        drive_sources();
        clr_cnt = 1'b1;
        @(negedge hclk);
        check("clr_beat_present", {31'd0, s0_tready & sv[0]}, 1);
        fin();
        drive_sources();
        clr_cnt = 1'b0;
        @(negedge hclk);
        check("clr_wins", {22'd0, cnt0}, 0);
        fin();
        half();
        check("cnt_after_clr", {22'd0, cnt0}, 1);
        check("mid_pkt_valid", {31'd0, m_tvalid}, 1);
        fin();
        drive_sources();
        hresetn = 1'b0;
        @(negedge hclk);
        check("arst_grant", {30'd0, grant}, 0);
        check("arst_m_tvalid", {31'd0, m_tvalid}, 0);
        check("arst_m_tdata", {24'd0, m_tdata}, 0);
        check("arst_cnt0", {22'd0, cnt0}, 0);
        check("arst_s0_tready", {31'd0, s0_tready}, 0);
        fin();
        hresetn = 1'b1;
        gen_on[0] = 1'b0;
        repeat (4) step();

        // Randomized traffic against the model.
        do_reset();
        manual = 1'b0;
        gen_on[0] = 1'b1; gen_on[1] = 1'b1;
        fix_len[0] = 0; fix_len[1] = 0;
        bip[0] = 0; bip[1] = 0;
        new_len(0); new_len(1);
        for (int i = 0; i < 4000; i++) begin
            pv[0] = 60;
            pv[1] = ((i / 300) % 2 == 1) ? 0 : 40;
            drive_sources();
            m_tready = (int'($urandom_range(0, 99)) < 75);
            clr_cnt  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) src_en[$urandom_range(0, 1)] ^= 1'b1;
            if (src_en != 2'b11 && $urandom_range(0, 7) == 0) src_en = 2'b11;
            @(negedge hclk);
            fin();
        end
        clr_cnt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
